// File: rtl/jt12_opseq_pkg.sv
// Shared definitions for the operator RAM slot sequencer:
// CPU write FSM states, default slot geometry and modular slot arithmetic.
package jt12_opseq_pkg;

  // Default number of active operator slots and read-to-write-back delay
  localparam int DEF_SLOTS = 24;
  localparam int DEF_PIPE  = 2;

  // CPU write-merge FSM
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PEND = 2'd1,
    ST_ACK  = 2'd2,
    ST_WAIT = 2'd3
  } opseq_state_t;

  // (a + b) mod n, for a in [0, n) and b >= 0
  function automatic int slot_add(input int a, input int b, input int n);
    return (a + b) % n;
  endfunction

  // (a - b) mod n, for a in [0, n) and b >= 0; result is never negative
  function automatic int slot_sub(input int a, input int b, input int n);
    return (a - (b % n) + n) % n;
  endfunction

endpackage

// File: rtl/jt12_opram_seq_if.sv
// CPU-side write request bus of the operator RAM sequencer.
// The master raises cpu_req with slot/data/mask held stable until cpu_ack.
interface jt12_opram_seq_if #(
  parameter int DW = 44,
  parameter int AW = 5
);
  logic          cpu_req;
  logic [AW-1:0] cpu_slot;
  logic [DW-1:0] cpu_data;
  logic [DW-1:0] cpu_mask;
  logic          cpu_ack;
  logic          cpu_err;

  modport master (
    output cpu_req, cpu_slot, cpu_data, cpu_mask,
    input  cpu_ack, cpu_err
  );

  modport slave (
    input  cpu_req, cpu_slot, cpu_data, cpu_mask,
    output cpu_ack, cpu_err
  );
endinterface

// File: rtl/jt12_opseq_slotcnt.sv
// Wrapping slot counter. cur_slot walks 0..SLOTS-1; rd_addr runs one slot
// ahead (the RAM read is registered) and wr_addr trails by PIPE slots.
// All outputs are registered and only move when clk_en is high.
module jt12_opseq_slotcnt
  import jt12_opseq_pkg::*;
#(
  parameter int AW    = 5,
  parameter int SLOTS = DEF_SLOTS,
  parameter int PIPE  = DEF_PIPE
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clk_en,
  output logic [AW-1:0] cur_slot,
  output logic [AW-1:0] rd_addr,
  output logic [AW-1:0] wr_addr,
  output logic          sync
);

  localparam logic [AW-1:0] RD_RST = AW'(slot_add(0, 1, SLOTS));
  localparam logic [AW-1:0] WR_RST = AW'(slot_sub(0, PIPE, SLOTS));

  logic [AW-1:0] r_cur;
  logic [AW-1:0] r_rd;
  logic [AW-1:0] r_wr;
  logic          r_sync;

  logic [AW-1:0] w_cur_next;
  logic [AW-1:0] w_rd_next;
  logic [AW-1:0] w_wr_next;

  assign w_cur_next = AW'(slot_add(int'(r_cur), 1, SLOTS));
  assign w_rd_next  = AW'(slot_add(int'(r_rd), 1, SLOTS));
  assign w_wr_next  = AW'(slot_add(int'(r_wr), 1, SLOTS));

  // Advance the current slot and both address pointers together on each strobe
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cur  <= '0;
      r_rd   <= RD_RST;
      r_wr   <= WR_RST;
      r_sync <= 1'b1;
    end else if (clk_en) begin
      r_cur  <= w_cur_next;
      r_rd   <= w_rd_next;
      r_wr   <= w_wr_next;
      r_sync <= (w_cur_next == '0);
    end
  end

  assign cur_slot = r_cur;
  assign rd_addr  = r_rd;
  assign wr_addr  = r_wr;
  assign sync     = r_sync;

endmodule

// File: rtl/jt12_opram_seq.sv
// Operator state RAM sequencer and write-back controller.
// Walks the active slots, drives RAM read/write addresses, writes pipeline
// state back every strobe and merges one CPU write at a time into that
// write-back stream when its slot comes round.
// Build option: define JT12_OPSEQ_MASK_EN to honour cpu_mask bitwise;
// otherwise a CPU merge replaces the whole word.
module jt12_opram_seq
  import jt12_opseq_pkg::*;
#(
  parameter int DW    = 44,
  parameter int AW    = 5,
  parameter int SLOTS = DEF_SLOTS,
  parameter int PIPE  = DEF_PIPE
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clk_en,
  input  logic [DW-1:0]         pipe_din,
  jt12_opram_seq_if.slave       cpu,
  output logic [AW-1:0]         rd_addr,
  output logic [AW-1:0]         wr_addr,
  output logic [DW-1:0]         wr_data,
  output logic [AW-1:0]         cur_slot,
  output logic                  sync
);

  opseq_state_t  r_state;
  opseq_state_t  w_state_next;
  logic [AW-1:0] r_slot;
  logic [DW-1:0] r_data;
  logic          r_err;

  logic          w_capture;
  logic          w_merge;
  logic          w_slot_bad;
  logic [DW-1:0] w_merged;

  jt12_opseq_slotcnt #(
    .AW    (AW),
    .SLOTS (SLOTS),
    .PIPE  (PIPE)
  ) u_slotcnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .clk_en   (clk_en),
    .cur_slot (cur_slot),
    .rd_addr  (rd_addr),
    .wr_addr  (wr_addr),
    .sync     (sync)
  );

  assign w_slot_bad = (int'(cpu.cpu_slot) >= SLOTS);

  // FSM state register; a reset drops any pending write without an ack
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next state plus capture/merge strobes. Capture only happens in IDLE, so a
  // request can never merge in the same cycle it is accepted.
  always_comb begin
    w_state_next = r_state;
    w_capture    = 1'b0;
    w_merge      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (clk_en && cpu.cpu_req) begin
          w_capture    = 1'b1;
          w_state_next = w_slot_bad ? ST_ACK : ST_PEND;
        end
      end
      ST_PEND: begin
        if (clk_en && (wr_addr == r_slot)) begin
          w_merge      = 1'b1;
          w_state_next = ST_ACK;
        end
      end
      ST_ACK: begin
        w_state_next = ST_WAIT;
      end
      ST_WAIT: begin
        if (!cpu.cpu_req) begin
          w_state_next = ST_IDLE;
        end
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  // Holding register for the accepted request
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_slot <= '0;
      r_data <= '0;
      r_err  <= 1'b0;
    end else if (w_capture) begin
      r_slot <= cpu.cpu_slot;
      r_data <= cpu.cpu_data;
      r_err  <= w_slot_bad;
    end
  end

`ifdef JT12_OPSEQ_MASK_EN
  logic [DW-1:0] r_mask;

  // Mask bits of the holding register, captured alongside slot and data
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mask <= '0;
    end else if (w_capture) begin
      r_mask <= cpu.cpu_mask;
    end
  end

  // Bitwise merge: masked bits from the CPU, the rest from the pipeline
  for (genvar gi = 0; gi < DW; gi++) begin : g_merge
    assign w_merged[gi] = r_mask[gi] ? r_data[gi] : pipe_din[gi];
  end
`else
  logic w_unused_mask;

  // Without masking the CPU word replaces the whole write-back word
  assign w_unused_mask = ^cpu.cpu_mask;
  assign w_merged      = r_data;
`endif

  assign wr_data     = w_merge ? w_merged : pipe_din;
  assign cpu.cpu_ack = (r_state == ST_ACK);
  assign cpu.cpu_err = (r_state == ST_ACK) && r_err;

endmodule

// File: tb/tb_jt12_opram_seq.sv
// Self-checking bench for jt12_opram_seq: directed scenarios followed by
// randomized traffic, every cycle compared against a slot/request model.
// Honours JT12_OPSEQ_MASK_EN the same way as the design build.
module tb_jt12_opram_seq;

  localparam int DW    = 44;
  localparam int AW    = 5;
  localparam int SLOTS = 24;
  localparam int PIPE  = 2;

  logic          clk;
  logic          rst_n;
  logic          clk_en;
  logic [DW-1:0] pipe_din;
  logic [AW-1:0] rd_addr;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic [AW-1:0] cur_slot;
  logic          sync;

  jt12_opram_seq_if #(.DW(DW), .AW(AW)) cpu_if ();

  jt12_opram_seq #(
    .DW(DW), .AW(AW), .SLOTS(SLOTS), .PIPE(PIPE)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .clk_en   (clk_en),
    .pipe_din (pipe_din),
    .cpu      (cpu_if.slave),
    .rd_addr  (rd_addr),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .cur_slot (cur_slot),
    .sync     (sync)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: slot position counted in strobes since reset, plus the
  // life of one outstanding request expressed as strobes left until merge.
  int            m_cnt;
  bit            m_pending;
  int            m_left;
  logic [DW-1:0] m_data;
  logic [DW-1:0] m_mask;
  bit            m_ack;
  bit            m_err;
  bit            m_hold;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_cnt     = 0;
    m_pending = 1'b0;
    m_left    = 0;
    m_ack     = 1'b0;
    m_err     = 1'b0;
    m_hold    = 1'b0;
  endtask

  function automatic int model_wr();
    return (m_cnt - PIPE + SLOTS) % SLOTS;
  endfunction

  // One clock: entered just after a rising edge with inputs already driven.
  task automatic run_cycle();
    int            cur;
    int            rd;
    int            wr;
    int            k;
    bit            merge;
    bit            seen_ack;
    logic [DW-1:0] exp_wd;
    #3;
    if (!rst_n) model_reset();
    cur   = m_cnt;
    rd    = (cur + 1) % SLOTS;
    wr    = (cur - PIPE + SLOTS) % SLOTS;
    merge = rst_n && m_pending && clk_en && (m_left == 1);
`ifdef JT12_OPSEQ_MASK_EN
    exp_wd = merge ? ((pipe_din & ~m_mask) | (m_data & m_mask)) : pipe_din;
`else
    exp_wd = merge ? m_data : pipe_din;
`endif
    chk("cur_slot", 64'(cur_slot), 64'(cur));
    chk("rd_addr",  64'(rd_addr),  64'(rd));
    chk("wr_addr",  64'(wr_addr),  64'(wr));
    chk("sync",     64'(sync),     64'(cur == 0));
    chk("wr_data",  64'(wr_data),  64'(exp_wd));
    chk("cpu_ack",  64'(cpu_if.cpu_ack), 64'(m_ack));
    chk("cpu_err",  64'(cpu_if.cpu_err), 64'(m_ack && m_err));
    seen_ack = cpu_if.cpu_ack;
    if (seen_ack)
      $display("txn ack slot=%0d err=%0b data=%h mask=%h t=%0t",
               cpu_if.cpu_slot, cpu_if.cpu_err, m_data, m_mask, $time);
    @(posedge clk);
    if (rst_n) begin
      if (m_ack) begin
        m_ack  = 1'b0;
        m_hold = 1'b1;
      end else if (m_hold) begin
        if (!cpu_if.cpu_req) m_hold = 1'b0;
      end else if (m_pending) begin
        if (clk_en) begin
          if (m_left == 1) begin
            m_pending = 1'b0;
            m_ack     = 1'b1;
            m_err     = 1'b0;
          end else begin
            m_left--;
          end
        end
      end else if (clk_en && cpu_if.cpu_req) begin
        m_data = cpu_if.cpu_data;
        m_mask = cpu_if.cpu_mask;
        if (int'(cpu_if.cpu_slot) >= SLOTS) begin
          m_ack = 1'b1;
          m_err = 1'b1;
        end else begin
          k = (int'(cpu_if.cpu_slot) - wr + SLOTS) % SLOTS;
          m_left    = (k == 0) ? SLOTS : k;
          m_pending = 1'b1;
        end
      end
      if (clk_en) m_cnt = (m_cnt + 1) % SLOTS;
    end
    #1;
    if (seen_ack) cpu_if.cpu_req = 1'b0;
  endtask

  task automatic raise_req(input logic [AW-1:0] slot, input logic [DW-1:0] data,
                           input logic [DW-1:0] mask);
    cpu_if.cpu_slot = slot;
    cpu_if.cpu_data = data;
    cpu_if.cpu_mask = mask;
    cpu_if.cpu_req  = 1'b1;
  endtask

  initial begin
    int acks_seen;
    model_reset();
    m_data          = '0;
    m_mask          = '0;
    rst_n           = 1'b0;
    clk_en          = 1'b0;
    pipe_din        = '0;
    cpu_if.cpu_req  = 1'b0;
    cpu_if.cpu_slot = '0;
    cpu_if.cpu_data = '0;
    cpu_if.cpu_mask = '0;
    @(posedge clk);
    #1;

    // Reset values, then a full walk of the slot counter
    repeat (3) run_cycle();
    rst_n  = 1'b1;
    clk_en = 1'b1;
    repeat (26) run_cycle();

    // Full-word write to slot 5 over a zero pipeline
    raise_req(AW'(5), DW'(44'hABC), DW'(44'hFFF));
    repeat (30) run_cycle();

    // Partial mask merge into slot 7
    pipe_din = DW'(44'hF0F0);
    raise_req(AW'(7), DW'(44'h1234), DW'(44'h00FF));
    repeat (30) run_cycle();
    pipe_din = '0;

    // Out-of-range slot: error ack, no write-back altered
    raise_req(AW'(30), DW'(44'h5A5), DW'(44'hFFF));
    repeat (6) run_cycle();

    // Capture while wr_addr already matches, with clk_en toggling afterwards
    pipe_din = DW'(44'h111);
    raise_req(AW'(model_wr()), DW'(44'hBEEF), {DW{1'b1}});
    run_cycle();
    for (int c = 0; c < 60; c++) begin
      clk_en = (c % 2 == 1);
      run_cycle();
    end
    clk_en = 1'b1;
    repeat (4) run_cycle();

    // Reset in the middle of a pending write: nothing acked, re-request works
    raise_req(AW'((model_wr() + 10) % SLOTS), DW'(44'h777), {DW{1'b1}});
    repeat (4) run_cycle();
    chk("pend_before_rst", 64'(m_pending), 64'(1));
    rst_n          = 1'b0;
    cpu_if.cpu_req = 1'b0;
    repeat (2) run_cycle();
    rst_n = 1'b1;
    repeat (30) run_cycle();
    raise_req(AW'(3), DW'(44'hCAFE), {DW{1'b1}});
    acks_seen = 0;
    for (int c = 0; c < 30; c++) begin
      if (cpu_if.cpu_ack) acks_seen++;
      run_cycle();
    end
    chk("rereq_acked", 64'(acks_seen), 64'(1));

    // Randomized traffic
    for (int c = 0; c < 2000; c++) begin
      clk_en   = ($urandom_range(0, 3) != 0);
      pipe_din = DW'({$urandom(), $urandom()});
      if (!cpu_if.cpu_req && !m_hold && !m_ack && ($urandom_range(0, 5) == 0)) begin
        raise_req(($urandom_range(0, 9) == 0) ? AW'($urandom_range(SLOTS, 31))
                                              : AW'($urandom_range(0, SLOTS - 1)),
                  DW'({$urandom(), $urandom()}), DW'({$urandom(), $urandom()}));
      end
      run_cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
